adc_sample_sched: RTL and testbench



---
 rtl/adc_sched_pkg.sv | 20 ++
 rtl/adc_sched_fifo.sv | 63 ++++++
 rtl/adc_sample_sched.sv | 155 +++++++++++++++
 tb/tb_adc_sample_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC sample scheduler.
// Optional build macro: ADC_SCHED_SIGNED_EN (uses inv_msb below).
package adc_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StRun,
    StDrain
  } sched_state_e;

  // Saturation value of the dropped-sample counter.
  localparam logic [7:0] OvfMax = 8'hFF;

  // Offset-binary to two's complement: flip bit (w-1) of x.
  function automatic logic [31:0] inv_msb(input logic [31:0] x, input int unsigned w);
    return x ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/adc_sched_fifo.sv
// Synchronous sample FIFO. The head entry drives o_rdata straight from storage, so a
// sample written into an empty FIFO is visible the following cycle.
module adc_sched_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [CntW-1:0]   o_count
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(FIFO_DEPTH));
  // A pop on an empty FIFO is ignored; a push on a full one is accepted only with a pop.
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Sample storage; cleared on reset so m_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally (power-of-two depth); occupancy tracks 0..FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sample_sched.sv
// ADC sample scheduler: settle, decimate, burst/continuous capture into a FIFO feeding
// the FIR over valid/ready. Build macro ADC_SCHED_SIGNED_EN converts offset-binary codes
// to two's complement before they are written into the FIFO.
module adc_sample_sched
  import adc_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [15:0]       cfg_burst_len,
  input  logic [DATA_W-1:0] ad_pre_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        ovf_cnt
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [DIV_W-1:0]  r_div_q;
  logic [15:0]       r_burst_q;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [15:0]       r_tick_cnt;
  logic [SetW-1:0]   r_set_cnt;
  logic [7:0]        r_ovf;
  logic              r_done;

  logic              w_start_ok;
  logic              w_tick;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_burst_end;
  logic              w_full;
  logic              w_empty;
  logic [CntW-1:0]   w_fifo_cnt;
  logic [DATA_W-1:0] w_wdata;
  logic              w_done_nxt;

  // stop beats start when both arrive in IDLE.
  assign w_start_ok  = (r_state == StIdle) && start && !stop;
  assign w_tick      = (r_state == StRun) && (r_div_cnt == r_div_q);
  assign w_pop       = m_ready && !w_empty;
  assign w_push_ok   = w_tick && (!w_full || w_pop);
  assign w_drop      = w_tick && !w_push_ok;
  // Dropped ticks count too, so the burst spans a fixed time window.
  assign w_burst_end = w_tick && (r_burst_q != 16'd0) && (r_tick_cnt == r_burst_q - 16'd1);

`ifdef ADC_SCHED_SIGNED_EN
  assign w_wdata = DATA_W'(inv_msb(32'(ad_pre_data), DATA_W));
`else
  assign w_wdata = ad_pre_data;
`endif

  adc_sched_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_ok),
    .i_wdata (w_wdata),
    .i_pop   (m_ready),
    .o_rdata (m_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

  assign m_valid = !w_empty;
  assign busy    = (r_state != StIdle);
  assign done    = r_done;
  assign ovf_cnt = r_ovf;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_start_ok) w_state_nxt = StSettle;
      StSettle: begin
        if (stop) begin
          w_state_nxt = StDrain;
        end else if (r_set_cnt == SetW'(SETTLE_CYC - 1)) begin
          w_state_nxt = StRun;
        end
      end
      StRun:    if (stop || w_burst_end) w_state_nxt = StDrain;
      StDrain:  if (w_fifo_cnt == '0) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
    w_done_nxt = (r_state == StDrain) && (w_state_nxt == StIdle);
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Config latch at start; settle, divider and tick counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_q    <= '0;
      r_burst_q  <= '0;
      r_set_cnt  <= '0;
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else begin
      if (w_start_ok) begin
        r_div_q   <= cfg_div;
        r_burst_q <= cfg_burst_len;
      end
      r_set_cnt <= (r_state == StSettle) ? r_set_cnt + 1'b1 : '0;
      if (r_state != StRun || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (r_state == StIdle) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 16'd1;
      end
    end
  end

  // Saturating dropped-sample counter, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else if (w_start_ok) begin
      r_ovf <= '0;
    end else if (w_drop && (r_ovf != OvfMax)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

endmodule

// File: tb/tb_adc_sample_sched.sv
// Bench for adc_sample_sched: table-driven burst runs, hand-written corner sequences and
// randomized runs against a queue-based reference model. Honours ADC_SCHED_SIGNED_EN.
module tb_adc_sample_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, m_ready, m_valid, busy, done;
  logic [15:0] cfg_div, cfg_burst_len;
  logic [7:0]  ad_pre_data, m_data, ovf_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned div;
    int unsigned burst;
    bit          ready_low;  // hold m_ready low for the whole run
    int unsigned exp_n;
    int unsigned exp_ovf;
  } vec_t;

  vec_t vecs[5];

  adc_sample_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .cfg_div       (cfg_div),
    .cfg_burst_len (cfg_burst_len),
    .ad_pre_data   (ad_pre_data),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy),
    .done          (done),
    .ovf_cnt       (ovf_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] conv(input logic [7:0] x);
`ifdef ADC_SCHED_SIGNED_EN
    return x ^ 8'h80;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0; stop = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Wait up to 'bound' cycles for done with m_ready high; returns samples popped meanwhile.
  task automatic wait_done(input string name, input int bound, output int popped);
    bit seen = 0;
    popped = 0;
    m_ready = 1'b1;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      stop = 1'b0; start = 1'b0;
      if (m_valid) popped++;
      if (done) seen = 1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // Burst run from the table; sample k is the ramp value at tick k: 5 + d + k*(d+1).
  task automatic run_table(input vec_t v);
    int unsigned d, n, dones, first_t, ready_from, t_last;
    bit seen, fin;
    d = v.div; n = 0; dones = 0; first_t = 0; seen = 0; fin = 0;
    t_last = 5 + d + (v.burst - 1) * (d + 1);
    ready_from = v.ready_low ? t_last + 1 : 0;
    start = 1'b1; stop = 1'b0; cfg_div = 16'(d); cfg_burst_len = 16'(v.burst);
    ad_pre_data = 8'd0; m_ready = (ready_from == 0);
    for (int t = 1; t < 300 && !fin; t++) begin
      step();
      start = (t == 3);  // must be ignored while busy
      cfg_div = 16'($urandom); cfg_burst_len = 16'($urandom);
      ad_pre_data = 8'(t);
      m_ready = (t >= int'(ready_from));
      if (t == 1) chk("busy_after_start", 32'(busy), 32'd1);
      if (m_valid && !seen) begin seen = 1; first_t = t; end
      if (m_valid && m_ready) begin
        chk("tbl_sample", 32'(m_data), 32'(conv(8'(5 + d + n * (d + 1)))));
        n++;
      end
      if (done) begin
        dones++; fin = 1;
        chk("busy_low_with_done", 32'(busy), 32'd0);
      end
    end
    chk("tbl_done_seen", 32'(fin), 32'd1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dones++;
    end
    chk("tbl_count", n, v.exp_n);
    chk("tbl_ovf", 32'(ovf_cnt), v.exp_ovf);
    chk("tbl_done_once", dones, 1);
    chk("tbl_first_valid", first_t, 6 + d);
  endtask

  // Randomized run checked every cycle against a queue model. ts<1 means no stop.
  task automatic run_model(input int d, input int b, input int ts);
    logic [7:0] q[$];
    int  t_end, ovf_m;
    bit  busy_m, done_m, nbusy, ndone, fin, tick;
    t_end = 1 << 30;
    if (b != 0) t_end = 5 + d + (b - 1) * (d + 1);
    if (ts >= 1 && ts < t_end) t_end = ts;
    busy_m = 0; done_m = 0; ovf_m = 0; fin = 0;
    start = 1'b1; stop = 1'b0; cfg_div = 16'(d); cfg_burst_len = 16'(b);
    m_ready = 1'($urandom); ad_pre_data = 8'($urandom);
    for (int t = 0; t < 500 && !fin; t++) begin
      if (t > 0) begin
        step();
        start = 1'b0; stop = (t == ts);
        m_ready = ($urandom_range(0, 3) != 0);
        ad_pre_data = 8'($urandom);
        cfg_div = 16'($urandom); cfg_burst_len = 16'($urandom);
        chk("mdl_valid", 32'(m_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("mdl_data", 32'(m_data), 32'(q[0]));
        chk("mdl_busy", 32'(busy), 32'(busy_m));
        chk("mdl_done", 32'(done), 32'(done_m));
        if (done_m) fin = 1;
      end
      // Effects of this cycle's inputs, seen next cycle.
      tick  = (t >= 5) && (t <= t_end) && (((t - 5) % (d + 1)) == d);
      ndone = busy_m && (t > t_end) && (q.size() == 0);
      nbusy = (t == 0) ? 1'b1 : (busy_m && !ndone);
      if (q.size() > 0 && m_ready) void'(q.pop_front());
      if (tick) begin
        if (q.size() < 8) q.push_back(conv(ad_pre_data));
        else if (ovf_m < 255) ovf_m++;
      end
      done_m = ndone; busy_m = nbusy;
    end
    chk("mdl_finished", 32'(fin), 32'd1);
    chk("mdl_ovf", 32'(ovf_cnt), 32'(ovf_m));
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int popped, d, b, ts;
    vecs[0] = '{div: 0, burst: 5,  ready_low: 0, exp_n: 5, exp_ovf: 0};
    vecs[1] = '{div: 0, burst: 20, ready_low: 1, exp_n: 8, exp_ovf: 12};
    vecs[2] = '{div: 3, burst: 6,  ready_low: 0, exp_n: 6, exp_ovf: 0};
    vecs[3] = '{div: 1, burst: 10, ready_low: 1, exp_n: 8, exp_ovf: 2};
    vecs[4] = '{div: 2, burst: 1,  ready_low: 0, exp_n: 1, exp_ovf: 0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; m_ready = 1'b0;
    cfg_div = '0; cfg_burst_len = '0; ad_pre_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    rst_n = 1'b1;
    idle(2);

    foreach (vecs[i]) begin
      run_table(vecs[i]);
      idle(2);
    end

    // Continuous, div=3: a sample appears every 4 cycles from cycle 9 after start.
    start = 1'b1; cfg_div = 16'd3; cfg_burst_len = 16'd0; m_ready = 1'b1;
    for (int t = 1; t < 40; t++) begin
      step();
      start = 1'b0;
      ad_pre_data = 8'(t);
      chk("cont_valid", 32'(m_valid), 32'(t >= 9 && ((t - 9) % 4) == 0));
    end
    stop = 1'b1;
    wait_done("cont_done", 20, popped);
    chk("cont_ovf", 32'(ovf_cnt), 32'd0);
    idle(2);

    // Full FIFO plus a pop on a tick (with stop): push kept, nothing dropped.
    start = 1'b1; cfg_div = 16'd0; cfg_burst_len = 16'd0; m_ready = 1'b0;
    ad_pre_data = 8'd0;
    popped = 0;
    for (int t = 1; t <= 15; t++) begin
      step();
      start = 1'b0;
      ad_pre_data = 8'(t);
      m_ready = (t == 13);
      stop = (t == 13);
      if (t == 13) chk("full_head", 32'(m_data), 32'(conv(8'd5)));
      if (t >= 14) begin
        chk("full_hold_valid", 32'(m_valid), 32'd1);
        chk("full_ovf", 32'(ovf_cnt), 32'd0);
      end
    end
    for (int k = 6; k <= 13; k++) begin
      m_ready = 1'b1;
      chk("full_drain_data", 32'(m_data), 32'(conv(8'(k))));
      step();
    end
    chk("full_empty_after_8", 32'(m_valid), 32'd0);
    wait_done("full_done", 5, popped);
    chk("full_no_extra", popped, 0);
    idle(2);

    // Stop during SETTLE (with an ignored start while busy): done exactly at cycle 4.
    start = 1'b1; cfg_div = 16'd0; cfg_burst_len = 16'd0;
    for (int t = 1; t <= 6; t++) begin
      step();
      start = (t == 1);
      stop  = (t == 2);
      chk("settle_stop_valid", 32'(m_valid), 32'd0);
      chk("settle_stop_done", 32'(done), 32'(t == 4));
    end
    idle(1);

    // start and stop together in IDLE: stays idle.
    start = 1'b1; stop = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      step();
      start = 1'b0; stop = 1'b0;
      chk("collide_busy", 32'(busy), 32'd0);
    end

    // Offset-binary conversion of the extreme codes.
    start = 1'b1; cfg_div = 16'd0; cfg_burst_len = 16'd2; m_ready = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      step();
      start = 1'b0;
      ad_pre_data = (t == 5) ? 8'h80 : (t == 6) ? 8'h00 : 8'h55;
      if (t == 6) chk("sign_80", 32'(m_data), 32'(conv(8'h80)));
      if (t == 7) chk("sign_00", 32'(m_data), 32'(conv(8'h00)));
    end
    wait_done("sign_done", 10, popped);
    idle(2);

    // Reset mid-run clears outputs at once, no done afterwards.
    start = 1'b1; cfg_div = 16'd0; cfg_burst_len = 16'd0; m_ready = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      step();
      start = 1'b0;
      ad_pre_data = 8'(t);
    end
    chk("pre_reset_valid", 32'(m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(m_valid), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_ovf", 32'(ovf_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("post_reset_done", 32'(done), 32'd0);
      chk("post_reset_busy", 32'(busy), 32'd0);
    end
    idle(1);

    // Randomized runs against the model.
    for (int r = 0; r < 24; r++) begin
      d = $urandom_range(0, 3);
      b = $urandom_range(0, 12);
      if (b == 0) ts = $urandom_range(1, 50);
      else ts = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : -1;
      run_model(d, b, ts);
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
